// File: rtl/frame_mode_sequencer.sv
// Frame-level mode sequencer: commits display-mode changes only between frames and
// runs the clear / collect / apply cycle that the statistics-based modes need.
module frame_mode_sequencer #(
  parameter int                MODE_W       = 18,
  parameter logic [MODE_W-1:0] STATS_MASK   = 18'h00198,
  parameter int                CLEAR_CYCLES = 256
) (
  input  logic              CCD_PIXCLK,
  input  logic              iRst_n,
  input  logic [MODE_W-1:0] iDisplaySelect,
  input  logic              iFval,
  output logic [MODE_W-1:0] oMode,
  output logic              oStatsCollect,
  output logic              oStatsApply,
  output logic              oClrWe,
  output logic [7:0]        oClrAddr,
  output logic              oBusy,
  output logic              oFrameDone,
  output logic [15:0]       oFrameCnt,
  output logic              oInvalidSel
);

  localparam logic [7:0]        CLR_LAST = 8'(CLEAR_CYCLES - 1);
  localparam logic [MODE_W-1:0] ONE      = {{(MODE_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {BLANK, CLEAR, WAIT_LOW, ACTIVE} state_t;
  typedef enum logic [1:0] {PLAIN, COLLECT, APPLY} phase_t;

  state_t            state;
  phase_t            phase;
  logic [7:0]        clr_cnt;
  logic [MODE_W-1:0] sel_m;
  logic [MODE_W-1:0] sel_s;
  logic              fval_q;
  logic              fval_d;

  logic rise;
  logic fall;
  logic legal;
  logic pending;
  logic sel_stats;

  assign rise      = ~fval_d & fval_q;
  assign fall      = fval_d & ~fval_q;
  // At most one bit set: clearing the lowest set bit leaves nothing.
  assign legal     = ((sel_s & (sel_s - ONE)) == '0);
  assign pending   = legal && (sel_s != oMode);
  assign sel_stats = |(sel_s & STATS_MASK);

  always_ff @(posedge CCD_PIXCLK or negedge iRst_n) begin
    if (!iRst_n) begin
      sel_m  <= '0;
      sel_s  <= '0;
      fval_q <= 1'b0;
      fval_d <= 1'b0;
    end else begin
      sel_m  <= iDisplaySelect;
      sel_s  <= sel_m;
      fval_q <= iFval;
      fval_d <= fval_q;
    end
  end

  always_ff @(posedge CCD_PIXCLK or negedge iRst_n) begin
    if (!iRst_n) begin
      state         <= BLANK;
      phase         <= PLAIN;
      clr_cnt       <= '0;
      oMode         <= '0;
      oStatsCollect <= 1'b0;
      oStatsApply   <= 1'b0;
      oClrWe        <= 1'b0;
      oClrAddr      <= '0;
      oBusy         <= 1'b0;
      oFrameDone    <= 1'b0;
      oFrameCnt     <= '0;
      oInvalidSel   <= 1'b0;
    end else begin
      // Outputs trail the state by one register so every iFval edge reaches the datapath in 3 cycles.
      oStatsCollect <= (state == ACTIVE) && (phase == COLLECT);
      oStatsApply   <= (state == ACTIVE) && (phase == APPLY);
      oClrWe        <= (state == CLEAR);
      oClrAddr      <= clr_cnt;
      oBusy         <= (state == CLEAR) || (state == WAIT_LOW);
      oFrameDone    <= fall;
      oInvalidSel   <= ~legal;
      if (fall) oFrameCnt <= oFrameCnt + 16'd1;

      case (state)
        BLANK: begin
          if (pending) begin
            oMode <= sel_s;
            if (sel_stats) begin
              state   <= CLEAR;
              clr_cnt <= '0;
            end else begin
              phase <= PLAIN;
              // A frame starting on the commit cycle is sat out rather than half-processed.
              if (fval_q) state <= WAIT_LOW;
            end
          end else if (fval_q) begin
            state <= rise ? ACTIVE : WAIT_LOW;
          end
        end
        CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            phase <= COLLECT;
            state <= fval_q ? WAIT_LOW : BLANK;
          end else begin
            clr_cnt <= clr_cnt + 8'd1;
          end
        end
        WAIT_LOW: begin
          if (!fval_q) state <= BLANK;
        end
        ACTIVE: begin
          if (!fval_q) begin
            case (phase)
              COLLECT: begin
                phase <= APPLY;
                state <= BLANK;
              end
              APPLY: begin
                state   <= CLEAR;
                clr_cnt <= '0;
              end
              default: state <= BLANK;
            endcase
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_mode_sequencer.sv
// Scoreboard bench for frame_mode_sequencer: per-frame and per-clear expectations are queued
// by the stimulus and retired when the DUT reports a frame end or finishes a clear burst.
module tb_frame_mode_sequencer;

  localparam int MODE_W = 18;

  logic              clk = 1'b0;
  logic              iRst_n;
  logic [MODE_W-1:0] iDisplaySelect;
  logic              iFval;
  logic [MODE_W-1:0] oMode;
  logic              oStatsCollect;
  logic              oStatsApply;
  logic              oClrWe;
  logic [7:0]        oClrAddr;
  logic              oBusy;
  logic              oFrameDone;
  logic [15:0]       oFrameCnt;
  logic              oInvalidSel;

  frame_mode_sequencer dut (
    .CCD_PIXCLK     (clk),
    .iRst_n         (iRst_n),
    .iDisplaySelect (iDisplaySelect),
    .iFval          (iFval),
    .oMode          (oMode),
    .oStatsCollect  (oStatsCollect),
    .oStatsApply    (oStatsApply),
    .oClrWe         (oClrWe),
    .oClrAddr       (oClrAddr),
    .oBusy          (oBusy),
    .oFrameDone     (oFrameDone),
    .oFrameCnt      (oFrameCnt),
    .oInvalidSel    (oInvalidSel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        collect;
    logic        apply;
    logic        busy;
    logic [15:0] cnt;
  } frame_t;

  frame_t      frame_q[$];
  int          clr_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = 16'd0;

  int   clr_len = 0;
  logic prev_we = 1'b0;
  logic acc_c   = 1'b0;
  logic acc_a   = 1'b0;
  logic hold    = 1'b0;
  logic both    = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: retires queued expectations as the DUT produces them.
  always @(negedge clk) begin
    if (!iRst_n) begin
      clr_len = 0;
      prev_we = 1'b0;
      acc_c   = 1'b0;
      acc_a   = 1'b0;
      hold    = 1'b0;
    end else begin
      if (oClrWe) begin
        check_val("clr_addr", {24'd0, oClrAddr}, clr_len & 32'hFF);
        clr_len++;
      end else if (prev_we) begin
        if (clr_q.size() == 0) check_val("clr_unexpected", clr_len, 0);
        else check_val("clr_len", clr_len, clr_q.pop_front());
        clr_len = 0;
      end
      prev_we = oClrWe;
      if (oStatsCollect && oStatsApply) both = 1'b1;
      if (hold) hold = 1'b0;
      else begin
        acc_c = acc_c | oStatsCollect;
        acc_a = acc_a | oStatsApply;
      end
      if (oFrameDone) begin
        if (frame_q.size() == 0) begin
          check_val("frame_unexpected", 1, 0);
        end else begin
          frame_t f;
          f = frame_q.pop_front();
          check_val("frame_collect", acc_c, f.collect);
          check_val("frame_apply", acc_a, f.apply);
          check_val("frame_busy", oBusy, f.busy);
          check_val("frame_cnt", oFrameCnt, f.cnt);
        end
        acc_c = 1'b0;
        acc_a = 1'b0;
        hold  = 1'b1;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input int hi, input int lo, input logic c, input logic a, input logic b);
    exp_cnt = exp_cnt + 16'd1;
    frame_q.push_back({c, a, b, exp_cnt});
    iFval = 1'b1;
    cycles(hi);
    iFval = 1'b0;
    cycles(lo);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst_n         = 1'b0;
    iFval          = 1'b0;
    iDisplaySelect = '0;
    cycles(3);
    check_val("rst_mode", oMode, 0);
    check_val("rst_collect", oStatsCollect, 0);
    check_val("rst_clrwe", oClrWe, 0);
    check_val("rst_busy", oBusy, 0);
    check_val("rst_cnt", oFrameCnt, 0);
    iRst_n = 1'b1;
    cycles(3);

    // Plain mode: 3-cycle commit latency, no clear, no statistics.
    iDisplaySelect = 18'h2;
    cycles(2);
    check_val("lat_old", oMode, 0);
    cycles(1);
    check_val("lat_new", oMode, 18'h2);
    cycles(4);
    run_frame(20, 10, 1'b0, 1'b0, 1'b0);

    // Statistics mode: clear, collect, apply, clear, collect, apply.
    iDisplaySelect = 18'h8;
    clr_q.push_back(256);
    cycles(3);
    check_val("stats_mode", oMode, 18'h8);
    cycles(270);
    run_frame(20, 10, 1'b1, 1'b0, 1'b0);
    run_frame(20, 10, 1'b0, 1'b1, 1'b0);
    clr_q.push_back(256);
    cycles(270);
    run_frame(20, 10, 1'b1, 1'b0, 1'b0);
    run_frame(20, 10, 1'b0, 1'b1, 1'b0);
    clr_q.push_back(256);
    cycles(270);

    // Request arriving mid-frame is deferred to blanking.
    iDisplaySelect = 18'h2;
    cycles(5);
    check_val("back_to_plain", oMode, 18'h2);
    exp_cnt = exp_cnt + 16'd1;
    frame_q.push_back({1'b0, 1'b0, 1'b0, exp_cnt});
    iFval = 1'b1;
    cycles(5);
    iDisplaySelect = 18'h4;
    cycles(10);
    check_val("mode_hold_in_frame", oMode, 18'h2);
    iFval = 1'b0;
    cycles(8);
    check_val("mode_after_fall", oMode, 18'h4);

    // Multi-bit request is flagged and ignored.
    iDisplaySelect = 18'h0A;
    cycles(4);
    check_val("invalid_flag", oInvalidSel, 1);
    check_val("invalid_mode", oMode, 18'h4);
    run_frame(20, 10, 1'b0, 1'b0, 1'b0);
    run_frame(20, 10, 1'b0, 1'b0, 1'b0);
    check_val("invalid_mode_after", oMode, 18'h4);

    // Frame starting inside a clear is skipped but counted.
    iDisplaySelect = 18'h10;
    clr_q.push_back(256);
    cycles(13);
    exp_cnt = exp_cnt + 16'd1;
    frame_q.push_back({1'b0, 1'b0, 1'b1, exp_cnt});
    iFval = 1'b1;
    cycles(300);
    check_val("skip_busy", oBusy, 1);
    check_val("skip_invalid_clr", oInvalidSel, 0);
    check_val("skip_mode", oMode, 18'h10);
    iFval = 1'b0;
    cycles(10);
    run_frame(20, 10, 1'b1, 1'b0, 1'b0);
    run_frame(20, 10, 1'b0, 1'b1, 1'b0);
    clr_q.push_back(256);
    cycles(270);

    // Frame counter wrap.
    force dut.oFrameCnt = 16'hFFFF;
    cycles(1);
    release dut.oFrameCnt;
    cycles(1);
    check_val("cnt_preload", oFrameCnt, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    run_frame(20, 10, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a clear drops everything; the mode is then re-committed with a full clear.
    iDisplaySelect = 18'h80;
    cycles(53);
    check_val("mid_clear_we", oClrWe, 1);
    #2;
    iRst_n = 1'b0;
    #1;
    check_val("arst_mode", oMode, 0);
    check_val("arst_collect", oStatsCollect, 0);
    check_val("arst_apply", oStatsApply, 0);
    check_val("arst_clrwe", oClrWe, 0);
    check_val("arst_clraddr", oClrAddr, 0);
    check_val("arst_busy", oBusy, 0);
    check_val("arst_done", oFrameDone, 0);
    check_val("arst_cnt", oFrameCnt, 0);
    check_val("arst_invalid", oInvalidSel, 0);
    cycles(2);
    iRst_n  = 1'b1;
    exp_cnt = 16'd0;
    clr_q.push_back(256);
    cycles(275);
    check_val("reselect_mode", oMode, 18'h80);
    run_frame(20, 10, 1'b1, 1'b0, 1'b0);

    check_val("collect_apply_overlap", both, 0);
    check_val("clr_q_empty", clr_q.size(), 0);
    check_val("frame_q_empty", frame_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
